// File: rtl/command_buffer_arbiter_rr.sv
// Round-robin / fixed-priority command arbiter with PSL credit gating and a registered winning command.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
package command_buffer_pkg;
   typedef enum logic [2:0] {
      INVALID    = 3'd0,
      READ_CL_NA = 3'd1,
      READ_CL_S  = 3'd2,
      WRITE_NA   = 3'd3,
      WRITE_MI   = 3'd4,
      TOUCH_I    = 3'd5,
      FLUSH      = 3'd6,
      INTREQ     = 3'd7
   } command_t;

   typedef enum logic [2:0] {
      STRICT = 3'd0,
      ABORT  = 3'd1,
      PAGE   = 3'd2,
      PREF   = 3'd3,
      SPEC   = 3'd4
   } abt_t;

   typedef struct packed {
      logic        valid;
      logic [12:0] cmd;
      command_t    command;
      logic [63:0] address;
      logic [11:0] size;
      abt_t        abt;
   } CommandBufferLine;

   localparam CommandBufferLine CMD_LINE_IDLE = '{
      valid: 1'b0, cmd: '0, command: INVALID, address: '0, size: '0, abt: STRICT
   };
endpackage

module command_buffer_arbiter_rr
   import command_buffer_pkg::*;
#(
   parameter int unsigned NUM_REQUESTS = 4,
   parameter int unsigned ROUND_ROBIN  = 1,
   parameter int unsigned CREDIT_WIDTH = 8,
   parameter int unsigned INIT_CREDITS = 64,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic                    clock,
   input  logic                    rstn,
   input  logic                    enabled_in,
   input  CommandBufferLine        command_buffer_in [NUM_REQUESTS],
   input  logic [NUM_REQUESTS-1:0] requests,
   input  logic                    credit_return_in,
   output CommandBufferLine        command_arbiter_out,
   output logic [NUM_REQUESTS-1:0] ready,
   output logic [CREDIT_WIDTH-1:0] credits_out,
   output logic                    credit_overflow
);
   localparam int unsigned IDX_W = $clog2(NUM_REQUESTS);
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

   logic                    enabled_q;
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
   logic                    overflow_q, overflow_d;
   CommandBufferLine        out_q, out_d;

   logic [NUM_REQUESTS-1:0] eligible;
   logic [NUM_REQUESTS-1:0] starved;
   logic [NUM_REQUESTS-1:0] grant;
   logic [IDX_W-1:0]        win_idx;
   logic                    grant_any;
   int unsigned             scan_idx;

   assign eligible = requests & {NUM_REQUESTS{enabled_q && (credits_q != '0)}};

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] wait_q [NUM_REQUESTS];

   always_comb begin
      starved = '0;
      for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
         starved[i] = eligible[i] && (wait_q[i] == SW'(STARVE_LIMIT));
      end
   end

   // Counters only advance while eligible, so credit or enable stalls freeze them.
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
            if (grant[i] || !requests[i]) begin
               wait_q[i] <= '0;
            end else if (eligible[i] && (wait_q[i] != SW'(STARVE_LIMIT))) begin
               wait_q[i] <= wait_q[i] + 1'b1;
            end
         end
      end
   end
`else
   assign starved = '0;
`endif

   always_comb begin
      grant     = '0;
      win_idx   = '0;
      grant_any = 1'b0;
      scan_idx  = 0;
      if (|starved) begin
         for (int unsigned i = 0; i < NUM_REQUESTS; i++) begin
            if (starved[i] && !grant_any) begin
               grant_any = 1'b1;
               win_idx   = IDX_W'(i);
            end
         end
      end else begin
         for (int unsigned k = 0; k < NUM_REQUESTS; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQUESTS;
            if (eligible[scan_idx] && !grant_any) begin
               grant_any = 1'b1;
               win_idx   = IDX_W'(scan_idx);
            end
         end
      end
      if (grant_any) begin
         grant[win_idx] = 1'b1;
      end
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      credits_d  = credits_q;
      overflow_d = overflow_q;
      out_d      = CMD_LINE_IDLE;
      if (grant_any) begin
         out_d = command_buffer_in[win_idx];
         if (ROUND_ROBIN != 0) begin
            rr_ptr_d = (win_idx == IDX_W'(NUM_REQUESTS - 1)) ? '0 : win_idx + 1'b1;
         end
      end
      // A return that coincides with a grant is absorbed by it and cannot overflow.
      if (grant_any && !credit_return_in) begin
         credits_d = credits_q - 1'b1;
      end else if (!grant_any && credit_return_in) begin
         if (credits_q == CREDIT_MAX) begin
            overflow_d = 1'b1;
         end else begin
            credits_d = credits_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         enabled_q  <= 1'b0;
         rr_ptr_q   <= '0;
         credits_q  <= CREDIT_WIDTH'(INIT_CREDITS);
         overflow_q <= 1'b0;
         out_q      <= CMD_LINE_IDLE;
      end else begin
         enabled_q  <= enabled_in;
         rr_ptr_q   <= rr_ptr_d;
         credits_q  <= credits_d;
         overflow_q <= overflow_d;
         out_q      <= out_d;
      end
   end

   assign ready               = grant;
   assign command_arbiter_out = out_q;
   assign credits_out         = credits_q;
   assign credit_overflow     = overflow_q;

endmodule
